// File: rtl/whitening_matrix_block.sv
// Whitening matrix V = D_inv_sqrt x E_T (4x4, signed Q32.32) computed with one shared
// 64x64 multiplier over 64 MAC cycles; results are published to V atomically.
module whitening_matrix_block (
    input  logic               CLK_wht,
    input  logic               RSTn_wht,
    input  logic               En_wht,
    input  logic               Start_wht,
    input  logic signed [63:0] E_T11,
    input  logic signed [63:0] E_T12,
    input  logic signed [63:0] E_T13,
    input  logic signed [63:0] E_T14,
    input  logic signed [63:0] E_T21,
    input  logic signed [63:0] E_T22,
    input  logic signed [63:0] E_T23,
    input  logic signed [63:0] E_T24,
    input  logic signed [63:0] E_T31,
    input  logic signed [63:0] E_T32,
    input  logic signed [63:0] E_T33,
    input  logic signed [63:0] E_T34,
    input  logic signed [63:0] E_T41,
    input  logic signed [63:0] E_T42,
    input  logic signed [63:0] E_T43,
    input  logic signed [63:0] E_T44,
    input  logic signed [63:0] D_inv_sqrt11,
    input  logic signed [63:0] D_inv_sqrt12,
    input  logic signed [63:0] D_inv_sqrt13,
    input  logic signed [63:0] D_inv_sqrt14,
    input  logic signed [63:0] D_inv_sqrt21,
    input  logic signed [63:0] D_inv_sqrt22,
    input  logic signed [63:0] D_inv_sqrt23,
    input  logic signed [63:0] D_inv_sqrt24,
    input  logic signed [63:0] D_inv_sqrt31,
    input  logic signed [63:0] D_inv_sqrt32,
    input  logic signed [63:0] D_inv_sqrt33,
    input  logic signed [63:0] D_inv_sqrt34,
    input  logic signed [63:0] D_inv_sqrt41,
    input  logic signed [63:0] D_inv_sqrt42,
    input  logic signed [63:0] D_inv_sqrt43,
    input  logic signed [63:0] D_inv_sqrt44,
    output logic signed [63:0] V11,
    output logic signed [63:0] V12,
    output logic signed [63:0] V13,
    output logic signed [63:0] V14,
    output logic signed [63:0] V21,
    output logic signed [63:0] V22,
    output logic signed [63:0] V23,
    output logic signed [63:0] V24,
    output logic signed [63:0] V31,
    output logic signed [63:0] V32,
    output logic signed [63:0] V33,
    output logic signed [63:0] V34,
    output logic signed [63:0] V41,
    output logic signed [63:0] V42,
    output logic signed [63:0] V43,
    output logic signed [63:0] V44,
    output logic               Busy_wht,
    output logic               Done_wht
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MAC     = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic        [1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [97:0] acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic signed [63:0] a_in [16];
    logic signed [63:0] b_in [16];
    logic signed [63:0] a_q  [16];
    logic signed [63:0] a_d  [16];
    logic signed [63:0] b_q  [16];
    logic signed [63:0] b_d  [16];
    logic signed [63:0] w_q  [16];
    logic signed [63:0] w_d  [16];
    logic signed [63:0] v_q  [16];
    logic signed [63:0] v_d  [16];

    logic signed [63:0]  mul_a, mul_b;
    logic        [127:0] mul_ext_a, mul_ext_b;
    logic signed [97:0]  term;
    logic signed [97:0]  sum;

    // Clamp the 98-bit accumulator into the signed 64-bit Q32.32 range.
    function automatic logic signed [63:0] sat64(input logic signed [97:0] x);
        if (!x[97] && (x[96:63] != '0)) begin
            return 64'sh7FFF_FFFF_FFFF_FFFF;
        end else if (x[97] && (x[96:63] != '1)) begin
            return 64'sh8000_0000_0000_0000;
        end else begin
            return $signed(x[63:0]);
        end
    endfunction

    // Row-major flattening: index (row-1)*4 + (col-1).
    assign a_in[0]  = D_inv_sqrt11;
    assign a_in[1]  = D_inv_sqrt12;
    assign a_in[2]  = D_inv_sqrt13;
    assign a_in[3]  = D_inv_sqrt14;
    assign a_in[4]  = D_inv_sqrt21;
    assign a_in[5]  = D_inv_sqrt22;
    assign a_in[6]  = D_inv_sqrt23;
    assign a_in[7]  = D_inv_sqrt24;
    assign a_in[8]  = D_inv_sqrt31;
    assign a_in[9]  = D_inv_sqrt32;
    assign a_in[10] = D_inv_sqrt33;
    assign a_in[11] = D_inv_sqrt34;
    assign a_in[12] = D_inv_sqrt41;
    assign a_in[13] = D_inv_sqrt42;
    assign a_in[14] = D_inv_sqrt43;
    assign a_in[15] = D_inv_sqrt44;

    assign b_in[0]  = E_T11;
    assign b_in[1]  = E_T12;
    assign b_in[2]  = E_T13;
    assign b_in[3]  = E_T14;
    assign b_in[4]  = E_T21;
    assign b_in[5]  = E_T22;
    assign b_in[6]  = E_T23;
    assign b_in[7]  = E_T24;
    assign b_in[8]  = E_T31;
    assign b_in[9]  = E_T32;
    assign b_in[10] = E_T33;
    assign b_in[11] = E_T34;
    assign b_in[12] = E_T41;
    assign b_in[13] = E_T42;
    assign b_in[14] = E_T43;
    assign b_in[15] = E_T44;

    // Shared multiplier: A[i][k] x B[k][j], floor-shifted back to Q32.32.
    assign mul_a     = a_q[{i_q, k_q}];
    assign mul_b     = b_q[{k_q, j_q}];
    assign mul_ext_a = {{64{mul_a[63]}}, mul_a};
    assign mul_ext_b = {{64{mul_b[63]}}, mul_b};
    assign term      = 98'($signed(mul_ext_a * mul_ext_b) >>> 32);
    assign sum       = acc_q + term;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        w_d     = w_q;
        v_d     = v_q;

        if (!En_wht) begin
            state_d = ST_IDLE;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            acc_d   = '0;
            busy_d  = 1'b0;
            for (int n = 0; n < 16; n++) begin
                v_d[n] = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start_wht) begin
                        a_d     = a_in;
                        b_d     = b_in;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        acc_d   = '0;
                        busy_d  = 1'b1;
                        state_d = ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (k_q == 2'd3) begin
                        w_d[{i_q, j_q}] = sat64(sum);
                        acc_d = '0;
                        k_d   = '0;
                        j_d   = j_q + 2'd1;
                        // Counters wrap to zero after the last element.
                        if (j_q == 2'd3) begin
                            i_d = i_q + 2'd1;
                            if (i_q == 2'd3) begin
                                state_d = ST_PUBLISH;
                            end
                        end
                    end else begin
                        acc_d = sum;
                        k_d   = k_q + 2'd1;
                    end
                end
                ST_PUBLISH: begin
                    v_d     = w_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_wht or negedge RSTn_wht) begin
        if (!RSTn_wht) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int n = 0; n < 16; n++) begin
                v_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            v_q     <= v_d;
        end
    end

    // Operand copies and the result buffer are only read after being written.
    always_ff @(posedge CLK_wht) begin
        a_q <= a_d;
        b_q <= b_d;
        w_q <= w_d;
    end

    assign V11 = v_q[0];
    assign V12 = v_q[1];
    assign V13 = v_q[2];
    assign V14 = v_q[3];
    assign V21 = v_q[4];
    assign V22 = v_q[5];
    assign V23 = v_q[6];
    assign V24 = v_q[7];
    assign V31 = v_q[8];
    assign V32 = v_q[9];
    assign V33 = v_q[10];
    assign V34 = v_q[11];
    assign V41 = v_q[12];
    assign V42 = v_q[13];
    assign V43 = v_q[14];
    assign V44 = v_q[15];

    assign Busy_wht = busy_q;
    assign Done_wht = done_q;

endmodule
